// File: rtl/dac_pkg.sv
// Shared encodings for the DAC waveform sequencer: waveform modes, FSM states,
// and the default I2C device address.
package dac_pkg;

  typedef enum logic [1:0] {
    MODE_DC  = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  localparam logic [6:0] DEV_ID_DEF = 7'h4C;

endpackage

// File: rtl/dac_tick_div.sv
// Sample-rate divider: one-cycle tick every DIV clocks while enabled, parked at 0 otherwise.
module dac_tick_div #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 16'd1;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/dac_wave_seq.sv
// Waveform sequencer: on each sample tick computes the next DC/saw/triangle/square
// sample and hands it to a downstream DAC write controller with a ready handshake.
module dac_wave_seq
  import dac_pkg::*;
#(
  parameter int          DIV    = 1000,
  parameter int          ACK_TO = 255,
  parameter logic [6:0]  DEV_ID = DEV_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [7:0]  level,
  input  logic [7:0]  step,
  input  logic        dac_ready,
  output logic        wr_req,
  output logic [7:0]  wr_data,
  output logic [6:0]  device_id,
  output logic        busy,
  output logic [15:0] sample_cnt,
  output logic        overrun,
  output logic        err
);

  localparam logic [15:0] ACK_LAST = 16'(ACK_TO - 1);

  state_e      state_q;
  mode_e       mode_q;
  logic [7:0]  phase_q, phase_d;
  logic        dir_dn_q, dir_dn_d;
  logic        sq_low_q, sq_low_d;
  logic        wr_req_q, err_q;
  logic [7:0]  wr_data_q;
  logic [15:0] sample_cnt_q;
  logic [15:0] ack_cnt_q;
  logic        tick;

  dac_tick_div #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Mode is tracked while waiting for a tick; a change restarts the waveform
  // so the sample taken on that same tick already reflects the new mode.
  logic       latch_mode, mode_chg;
  mode_e      mode_eff;
  logic [7:0] phase_eff, sample;
  logic       dir_dn_eff, sq_low_eff;

  assign latch_mode = ((state_q == S_IDLE) && en) || (state_q == S_WAIT_TICK);
  assign mode_eff   = latch_mode ? mode_e'(mode) : mode_q;
  assign mode_chg   = (mode_eff != mode_q);
  assign phase_eff  = mode_chg ? 8'd0 : phase_q;
  assign dir_dn_eff = mode_chg ? 1'b0 : dir_dn_q;
  assign sq_low_eff = mode_chg ? 1'b0 : sq_low_q;

  always_comb begin
    sample = level;
    case (mode_eff)
      MODE_SAW, MODE_TRI: sample = phase_eff;
      MODE_SQR:           sample = sq_low_eff ? 8'd0 : level;
      default:            sample = level;
    endcase
  end

  // Waveform advance applied on each completed sample.
  logic [8:0] sum9;
  assign sum9 = {1'b0, phase_q} + {1'b0, step};

  always_comb begin
    phase_d  = phase_q;
    dir_dn_d = dir_dn_q;
    sq_low_d = sq_low_q;
    case (mode_q)
      MODE_SAW: phase_d = sum9[7:0];
      MODE_TRI: begin
        if (!dir_dn_q) begin
          if (sum9 >= 9'd255) begin
            phase_d  = 8'd255;
            dir_dn_d = 1'b1;
          end else begin
            phase_d = sum9[7:0];
          end
        end else if (phase_q <= step) begin
          phase_d  = 8'd0;
          dir_dn_d = 1'b0;
        end else begin
          phase_d = phase_q - step;
        end
      end
      MODE_SQR: sq_low_d = !sq_low_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_DC;
      phase_q      <= '0;
      dir_dn_q     <= 1'b0;
      sq_low_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
      sample_cnt_q <= '0;
      ack_cnt_q    <= '0;
    end else begin
      wr_req_q <= 1'b0;
      err_q    <= 1'b0;
      if (latch_mode) begin
        mode_q   <= mode_eff;
        phase_q  <= phase_eff;
        dir_dn_q <= dir_dn_eff;
        sq_low_q <= sq_low_eff;
      end
      case (state_q)
        S_IDLE: if (en) state_q <= S_WAIT_TICK;
        S_WAIT_TICK: begin
          if (tick) begin
            state_q   <= S_REQ;
            wr_req_q  <= 1'b1;
            wr_data_q <= sample;
          end else if (!en) begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          state_q   <= S_WAIT_ACK;
          ack_cnt_q <= 16'd1;
        end
        // Dwell counts from the wr_req cycle, so err lands ACK_TO cycles after it.
        S_WAIT_ACK: begin
          if (!dac_ready) begin
            state_q <= S_WAIT_DONE;
          end else if (ack_cnt_q == ACK_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT_TICK;
          end else begin
            ack_cnt_q <= ack_cnt_q + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (dac_ready) begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
            phase_q      <= phase_d;
            dir_dn_q     <= dir_dn_d;
            sq_low_q     <= sq_low_d;
            state_q      <= en ? S_WAIT_TICK : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;
  assign sample_cnt = sample_cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = tick && (state_q != S_WAIT_TICK);
  assign device_id  = DEV_ID;

endmodule

// File: tb/tb_dac_wave_seq.sv
// Directed bench for dac_wave_seq with a simple DAC controller model on dac_ready.
module tb_dac_wave_seq;
  import dac_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, dac_ready;
  logic [1:0]  mode;
  logic [7:0]  level, step;
  logic        wr_req, busy, overrun, err;
  logic [7:0]  wr_data;
  logic [6:0]  device_id;
  logic [15:0] sample_cnt;

  always #5 clk = ~clk;

  dac_wave_seq #(.DIV(16), .ACK_TO(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .level      (level),
    .step       (step),
    .dac_ready  (dac_ready),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .device_id  (device_id),
    .busy       (busy),
    .sample_cnt (sample_cnt),
    .overrun    (overrun),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC controller model: drops ready after seeing wr_req, holds it low for 'hold' cycles.
  int hold  = 3;
  bit stuck = 1'b0;
  int mbusy = 0;
  always @(negedge clk) begin
    if (mbusy > 0) begin
      mbusy = mbusy - 1;
      if (mbusy == 0) dac_ready = 1'b1;
    end else if (wr_req && !stuck) begin
      dac_ready = 1'b0;
      mbusy     = hold;
    end
  end

  logic [7:0] wq[$];
  logic [7:0] exp_q[$];
  int req_n = 0, ovr_n = 0, err_n = 0, last_req_cyc = 0;
  always @(negedge clk) begin
    if (wr_req) begin
      wq.push_back(wr_data);
      req_n        = req_n + 1;
      last_req_cyc = cyc;
    end
    if (overrun) ovr_n = ovr_n + 1;
    if (err)     err_n = err_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cnt(input int target, input string tag);
    for (int i = 0; i < 400 && int'(sample_cnt) != target; i++) @(negedge clk);
    check(tag, 32'(sample_cnt), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input state_e s, input string tag);
    for (int i = 0; i < 200 && dut.state_q != s; i++) @(negedge clk);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wq.size()) check($sformatf("%s_%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_req"},  32'(wr_req),     32'd0);
    check({tag, "_wr_data"}, 32'(wr_data),    32'd0);
    check({tag, "_busy"},    32'(busy),       32'd0);
    check({tag, "_cnt"},     32'(sample_cnt), 32'd0);
    check({tag, "_overrun"}, 32'(overrun),    32'd0);
    check({tag, "_err"},     32'(err),        32'd0);
    check({tag, "_devid"},   32'(device_id),  32'h4C);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; level = 8'd0; step = 8'd0; dac_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Saw
    wq.delete(); mode = 2'd1; step = 8'd64; en = 1'b1;
    wait_cnt(5, "saw_cnt");
    en = 1'b0; wait_idle("saw_idle");
    exp_q = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
    check_seq("saw");

    // Triangle
    wq.delete(); mode = 2'd2; step = 8'd100; en = 1'b1;
    wait_cnt(13, "tri_cnt");
    en = 1'b0; wait_idle("tri_idle");
    exp_q = '{8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    check_seq("tri");

    // Square
    wq.delete(); mode = 2'd3; level = 8'hA5; en = 1'b1;
    wait_cnt(17, "sqr_cnt");
    en = 1'b0; wait_idle("sqr_idle");
    exp_q = '{8'hA5, 8'h00, 8'hA5, 8'h00};
    check_seq("sqr");

    // DC
    wq.delete(); mode = 2'd0; level = 8'h3C; en = 1'b1;
    wait_cnt(20, "dc_cnt");
    en = 1'b0; wait_idle("dc_idle");
    exp_q = '{8'h3C, 8'h3C, 8'h3C};
    check_seq("dc");

    // Overrun: DAC holds ready low across the next tick
    hold = 20; req_n = 0; ovr_n = 0; en = 1'b1;
    wait_cnt(21, "ovr_cnt");
    en = 1'b0; wait_idle("ovr_idle");
    check("ovr_pulses", 32'(ovr_n), 32'd1);
    check("ovr_reqs",   32'(req_n), 32'd1);
    hold = 3;

    // Handshake timeout
    stuck = 1'b1; err_n = 0; en = 1'b1;
    for (int i = 0; i < 100 && !err; i++) @(negedge clk);
    check("to_err",   32'(err), 32'd1);
    check("to_delay", 32'(cyc - last_req_cyc), 32'd8);
    check("to_state", 32'(dut.state_q), 32'(S_WAIT_TICK));
    check("to_cnt",   32'(sample_cnt), 32'd21);
    en = 1'b0; wait_idle("to_idle");
    check("to_err_n", 32'(err_n), 32'd1);
    stuck = 1'b0;

    // Reset while in WAIT_DONE
    hold = 20; err_n = 0; en = 1'b1;
    wait_state(S_WAIT_DONE, "rst_reach");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0; en = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_err", 32'(err_n), 32'd0);
    hold = 3;

    // en dropped during WAIT_ACK: handshake still completes
    en = 1'b1;
    wait_state(S_WAIT_ACK, "endrop_reach");
    en = 1'b0;
    wait_cnt(1, "endrop_cnt");
    check("endrop_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
